// File: rtl/addsub_pkg.sv
// Shared types and the combinational add/subtract function used by the
// pipelined add/subtract unit.
package addsub_pkg;

  localparam int OP_W  = 2;
  localparam int MAX_W = 32;

  typedef enum logic [OP_W-1:0] {
    ADD      = 2'd0,
    SUB      = 2'd1,
    SUB_SAT  = 2'd2,
    ABS_DIFF = 2'd3
  } op_e;

  typedef struct packed {
    logic [MAX_W:0] y;
    logic           cb;
    logic           sat;
    logic           zero;
  } calc_res_t;

  // Operands arrive zero-extended to MAX_W; w is the real operand width
  // (w < MAX_W), and y is masked to w+1 bits so bit w is the carry/borrow.
  function automatic calc_res_t addsub_calc(input op_e op,
                                            input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b,
                                            input int unsigned w = MAX_W - 1);
    logic [MAX_W:0] ea;
    logic [MAX_W:0] eb;
    logic [MAX_W:0] mask;
    logic           lt;
    calc_res_t      res;
    ea   = {1'b0, a};
    eb   = {1'b0, b};
    mask = {(MAX_W+1){1'b1}} >> (MAX_W - w);
    lt   = (a < b);
    res  = '0;
    case (op)
      ADD: begin
        res.y  = (ea + eb) & mask;
        res.cb = |(res.y & mask & ~(mask >> 1));
      end
      SUB: begin
        res.y  = (ea - eb) & mask;
        res.cb = lt;
      end
      SUB_SAT: begin
        res.y   = lt ? '0 : ((ea - eb) & mask);
        res.sat = lt;
        res.cb  = lt;
      end
      ABS_DIFF: begin
        res.y  = lt ? (eb - ea) : (ea - eb);
        res.cb = lt;
      end
      default: ;
    endcase
    res.zero = (res.y == '0);
    return res;
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One elastic pipeline register: holds a single valid/data beat and accepts
// a new one whenever it is empty or its contents are leaving this cycle.
module addsub_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q;
  logic              valid_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              load;

  always_comb begin
    load    = !valid_q || out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = load;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined unsigned add/subtract unit with valid/ready flow control:
// arithmetic feeds a chain of PIPE_STAGES elastic registers (WIDTH < 32).
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_y,
  output logic             out_cb,
  output logic             out_sat,
  output logic             out_zero
);

  localparam int DATA_W = WIDTH + 4;

  calc_res_t         calc;
  logic [DATA_W-1:0] calc_data;
  logic              unused_calc_hi;

  always_comb begin
    calc = addsub_calc(op_e'(in_op), MAX_W'(in_a), MAX_W'(in_b), WIDTH);
  end

  assign calc_data      = {calc.y[WIDTH:0], calc.cb, calc.sat, calc.zero};
  assign unused_calc_hi = ^calc.y[MAX_W:WIDTH+1];

  // Each stage keeps its own handshake wires so the ready chain runs
  // between distinct signals rather than through one shared vector.
  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    logic              valid_in;
    logic              ready_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic              ready_down;
    logic [DATA_W-1:0] data_out;

    if (i == 0) begin : g_head
      assign valid_in = in_valid;
      assign data_in  = calc_data;
    end else begin : g_link
      assign valid_in = g_stage[i-1].valid_out;
      assign data_in  = g_stage[i-1].data_out;
    end

    if (i == PIPE_STAGES - 1) begin : g_tail
      assign ready_down = out_ready;
    end else begin : g_mid
      assign ready_down = g_stage[i+1].ready_in;
    end

    addsub_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (valid_in),
      .in_ready (ready_in),
      .in_data  (data_in),
      .out_valid(valid_out),
      .out_ready(ready_down),
      .out_data (data_out)
    );
  end

  assign in_ready  = !rst && g_stage[0].ready_in;
  assign out_valid = g_stage[PIPE_STAGES-1].valid_out;
  assign {out_y, out_cb, out_sat, out_zero} = g_stage[PIPE_STAGES-1].data_out;

endmodule
